// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the shared-ALU arbiter slice.
//   ALU_* : 2-bit op select codes (add/sub/and/or)
//   state_e : arbiter FSM state encoding
package alu_pkg;

    localparam int         DATA_W  = 32;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response bundle between the requesters and
// the shared-ALU arbiter.
//   req_valid/req_ready : per-requester handshake (req_ready is one-hot)
//   req_a/req_b         : packed operands, requester i at [32*i +: 32]
//   req_sel             : packed op selects, requester i at [2*i +: 2]
//   resp_*              : single result channel (valid/ready, data, zero, id)
// master = requester/consumer side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*2-1:0]  req_sel;
    logic               resp_valid;
    logic               resp_ready;
    logic [31:0]        resp_data;
    logic               resp_zero;
    logic [IDW-1:0]     resp_id;

    modport master (
        output req_valid, req_a, req_b, req_sel, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_zero, resp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, resp_ready,
        output req_ready, resp_valid, resp_data, resp_zero, resp_id
    );

endinterface

// File: rtl/alu.sv
// alu: combinational 32-bit ALU (add/sub/and/or) with zero flag.
//   i_a, i_b     : operands
//   i_sel        : op select (ALU_ADD/SUB/AND/OR)
//   o_out        : result, modulo 2^32
//   o_zero_flag  : 1 iff o_out == 0
module alu
    import alu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [1:0]  i_sel,
    output logic [31:0] o_out,
    output logic        o_zero_flag
);

    always_comb begin
        o_out = '0;
        case (i_sel)
            ALU_ADD: o_out = i_a + i_b;
            ALU_SUB: o_out = i_a - i_b;
            ALU_AND: o_out = i_a & i_b;
            ALU_OR:  o_out = i_a | i_b;
            default: o_out = '0;
        endcase
    end

    assign o_zero_flag = (o_out == 32'd0);

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_req   : request vector
//   i_ptr   : highest-priority index for this pick
//   i_en    : grant enable; no grant when low
//   o_grant : one-hot grant (all zero when disabled or no request)
//   o_idx   : binary index of the granted requester
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    always_comb begin
        logic [IDW:0]   v_sum;
        logic [IDW-1:0] v_j;
        logic           v_found;
        o_grant = '0;
        o_idx   = '0;
        v_found = 1'b0;
        v_sum   = '0;
        v_j     = '0;
        // Scan ptr, ptr+1, ... wrapping at NREQ; first hit wins.
        for (int k = 0; k < NREQ; k++) begin
            v_sum = {1'b0, i_ptr} + (IDW+1)'(k);
            if (v_sum >= NREQ_W) begin
                v_sum = v_sum - NREQ_W;
            end
            v_j = v_sum[IDW-1:0];
            if (i_en && !v_found && i_req[v_j]) begin
                v_found      = 1'b1;
                o_grant[v_j] = 1'b1;
                o_idx        = v_j;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU among NREQ requesters.
// Round-robin grant, operands latched on handshake, one EXEC cycle through
// the ALU, result registered and returned on a valid/ready channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_share_arbiter_if.slave (requests in, response out)
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no op in flight; grant window open
// ST_EXEC | ALU evaluating latched operands; result captured at end
// ST_RESP | response valid; grant window open only when resp_ready
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [1:0]      r_sel;
    logic [IDW-1:0]  r_id;
    logic            r_resp_valid;
    logic [31:0]     r_resp_data;
    logic            r_resp_zero;
    logic [IDW-1:0]  r_resp_id;

    logic            w_grant_en;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_hs;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic [1:0]      w_sel;
    logic [31:0]     w_alu_out;
    logic            w_alu_zero;

    // rst_n in the enable keeps req_ready low throughout reset.
    assign w_grant_en = rst_n &&
                        ((r_state == ST_IDLE) ||
                         ((r_state == ST_RESP) && bus.resp_ready));

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_grant_en),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign bus.req_ready = w_grant;
    assign w_hs          = |(w_grant & bus.req_valid);
    assign w_ptr_nxt     = (w_idx == LAST_IDX) ? '0 : w_idx + IDW'(1);

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_a   = bus.req_a[32*i +: 32];
                w_b   = bus.req_b[32*i +: 32];
                w_sel = bus.req_sel[2*i +: 2];
            end
        end
    end

    alu u_alu (
        .i_a         (r_a),
        .i_b         (r_b),
        .i_sel       (r_sel),
        .o_out       (w_alu_out),
        .o_zero_flag (w_alu_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_hs) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (bus.resp_ready) w_state_nxt = w_hs ? ST_EXEC : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sel        <= '0;
            r_id         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_zero  <= 1'b0;
            r_resp_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_a   <= w_a;
                r_b   <= w_b;
                r_sel <= w_sel;
                r_id  <= w_idx;
                r_ptr <= w_ptr_nxt;
            end
            if (r_state == ST_EXEC) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= w_alu_out;
                r_resp_zero  <= w_alu_zero;
                r_resp_id    <= r_id;
            end else if ((r_state == ST_RESP) && bus.resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_zero  = r_resp_zero;
    assign bus.resp_id    = r_resp_id;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        logic [31:0] d;
        logic        z;
        int          id;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    int          exp_grant_q[$];
    logic [31:0] exp_d [NREQ];
    int          gcnt [NREQ];
    int          n_checks    = 0;
    int          n_fail      = 0;
    int          cyc         = 0;
    int          last_hs_cyc = 0;
    int          hs_count    = 0;
    bit          prev_stall  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: response scoreboard plus grant-order and one-hot checks.
    always @(negedge clk) begin
        int w;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.resp_valid) begin
                if (!prev_stall) chk("latency", 32'(cyc - last_hs_cyc), 32'd2);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    chk("resp_data", bus.resp_data, exp_q[0].d);
                    chk("resp_zero", 32'(bus.resp_zero), 32'(exp_q[0].z));
                    chk("resp_id", 32'(bus.resp_id), 32'(exp_q[0].id));
                    if (!bus.resp_ready) chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
                    else void'(exp_q.pop_front());
                end
                prev_stall = !bus.resp_ready;
            end else begin
                prev_stall = 1'b0;
            end
            chk("onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
            if (|(bus.req_valid & bus.req_ready)) begin
                w = 0;
                for (int i = 0; i < NREQ; i++)
                    if (bus.req_valid[i] && bus.req_ready[i]) w = i;
                if (exp_grant_q.size() == 0) fail_now("unexpected_grant");
                else chk("grant_order", 32'(w), 32'(exp_grant_q.pop_front()));
                exp_q.push_back('{d: exp_d[w], z: (exp_d[w] == 32'd0), id: w});
                last_hs_cyc = cyc;
                gcnt[w]++;
                hs_count++;
            end
        end
    end

    task automatic set_req(input int r, input logic [1:0] sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] d);
        bus.req_a[32*r +: 32] = a;
        bus.req_b[32*r +: 32] = b;
        bus.req_sel[2*r +: 2] = sel;
        exp_d[r]              = d;
        bus.req_valid[r]      = 1'b1;
    endtask

    // Wait for n more grants; optionally withdraw each requester once granted.
    task automatic wait_grants(input int n, input bit drop);
        int base;
        int snap [NREQ];
        base = hs_count;
        for (int r = 0; r < NREQ; r++) snap[r] = gcnt[r];
        for (int i = 0; i < 200 && hs_count < base + n; i++) begin
            @(posedge clk);
            #1;
            if (drop) begin
                for (int r = 0; r < NREQ; r++) begin
                    if (gcnt[r] != snap[r]) begin
                        bus.req_valid[r] = 1'b0;
                        snap[r] = gcnt[r];
                    end
                end
            end
        end
        if (hs_count < base + n) fail_now("grant_timeout");
    endtask

    task automatic single(input int r, input logic [1:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] d);
        exp_grant_q.push_back(r);
        set_req(r, sel, a, b, d);
        wait_grants(1, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < NREQ; r++) begin
            exp_d[r] = '0;
            gcnt[r]  = 0;
        end
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_sel    = '0;
        bus.resp_ready = 1'b1;
        bus.req_valid  = '1;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_zero", 32'(bus.resp_zero), 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op
        single(0, ALU_ADD, 32'd5, 32'd3, 32'd8);
        drain();

        // Zero and wrap cases; last op on requester 3 leaves the pointer at 0
        single(0, ALU_OR,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
        single(1, ALU_SUB, 32'd7,         32'd7,         32'd0);
        single(2, ALU_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0);
        single(1, ALU_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE);
        single(3, ALU_AND, 32'h0000_F0F0, 32'h0000_0F0F, 32'd0);
        drain();

        // Contention: all four held valid, expect 0,1,2,3,0
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(2);
        exp_grant_q.push_back(3);
        exp_grant_q.push_back(0);
        set_req(0, ALU_ADD, 32'd1,         32'd2,         32'd3);
        set_req(1, ALU_SUB, 32'd10,        32'd4,         32'd6);
        set_req(2, ALU_AND, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00);
        set_req(3, ALU_OR,  32'd1,         32'd2,         32'd3);
        wait_grants(5, 1'b0);
        bus.req_valid = '0;
        drain();

        // Backpressure with requester 2 waiting
        bus.resp_ready = 1'b0;
        single(0, ALU_ADD, 32'd10, 32'd20, 32'd30);
        exp_grant_q.push_back(2);
        set_req(2, ALU_SUB, 32'd50, 32'd8, 32'd42);
        for (int i = 0; i < 20 && !bus.resp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        if (!bus.resp_valid) fail_now("bp_resp_timeout");
        repeat (5) @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("release_grant", 32'(bus.req_ready), 32'h4);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        drain();

        // Reset during EXEC, then requester 3 alone
        single(1, ALU_ADD, 32'd1, 32'd1, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        exp_grant_q.push_back(3);
        set_req(3, ALU_ADD, 32'h100, 32'h23, 32'h123);
        #1;
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        wait_grants(1, 1'b1);
        drain();

        // Reset during EXEC must clear the pointer: 0 beats 2 afterwards
        single(1, ALU_ADD, 32'd2, 32'd2, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("midrst2_resp_valid", 32'(bus.resp_valid), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(2);
        set_req(0, ALU_OR,  32'h0000_1200, 32'h0000_0034, 32'h0000_1234);
        set_req(2, ALU_AND, 32'h0000_FFFF, 32'h0000_0F0F, 32'h0000_0F0F);
        wait_grants(2, 1'b1);
        drain();

        // Operands change right after the handshake
        single(0, ALU_ADD, 32'd100, 32'd1, 32'd101);
        bus.req_a[31:0] = 32'hDEAD_0000;
        bus.req_b[31:0] = 32'h0000_BEEF;
        bus.req_sel[1:0] = ALU_OR;
        drain();

        if (exp_grant_q.size() != 0) fail_now("grants_outstanding");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
